fu_issue_queue: RTL and testbench

In-order issue buffer and round-robin scheduler that sits between dispatch and a bank of NUM_FU identical ALU functional units. It accepts decoded, operand-ready ALU operations through a valid/ready handshake and buffers up to DEPTH of them. Each cycle it issues the oldest one to an available FU, rotating FU priority so that no unit is starved. Issued operations drive one shared operation bus; only the selected FU's write_enable is asserted.

---
 rtl/fu_pkg.sv | 27 ++
 rtl/rr_picker.sv | 30 +++
 rtl/fu_issue_queue.sv | 112 +++++++++++
 tb/tb_fu_issue_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared types and constants for the ALU issue path: the queued operation
// record and the ALU opcode encodings.
package fu_pkg;

   localparam int TAG_W = 6;
   localparam int ROB_W = 6;

   localparam logic [3:0] ALU_NONE     = 4'b0000;
   localparam logic [3:0] ALU_OR       = 4'b0001;
   localparam logic [3:0] ALU_ADD      = 4'b0010;
   localparam logic [3:0] ALU_XOR      = 4'b0011;
   localparam logic [3:0] ALU_SRA      = 4'b1011;
   localparam logic [3:0] ALU_PASS_RHS = 4'b1111;

   // 4 + 1 + 1 + 3*32 + 6 + 6 = 114 bits
   typedef struct packed {
      logic [3:0]       alu_control;
      logic             alu_src;
      logic             is_for_lsq;
      logic [31:0]      imm;
      logic [31:0]      rs1_value;
      logic [31:0]      rs2_value;
      logic [TAG_W-1:0] tag;
      logic [ROB_W-1:0] rob_index;
   } fu_op_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: grants the first set request bit found
// searching circularly upward from ptr.
module rr_picker #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          any
);

   always_comb begin
      int j;
      j         = 0;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any && req[j]) begin
            any       = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = PW'(j);
         end
      end
   end

endmodule

// File: rtl/fu_issue_queue.sv
// In-order ALU issue queue: circular buffer of operand-ready ops, issuing the
// head to one available FU per cycle with rotating FU priority.
module fu_issue_queue
   import fu_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int NUM_FU = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_alu_control,
   input  logic                     in_alu_src,
   input  logic                     in_is_for_lsq,
   input  logic [31:0]              in_imm,
   input  logic [31:0]              in_rs1_value,
   input  logic [31:0]              in_rs2_value,
   input  logic [TAG_W-1:0]         in_tag,
   input  logic [ROB_W-1:0]         in_rob_index,
   input  logic [NUM_FU-1:0]        fu_is_available,
   output logic [NUM_FU-1:0]        fu_write_enable,
   output logic [3:0]               issue_alu_control,
   output logic                     issue_alu_src,
   output logic                     issue_is_for_lsq,
   output logic [31:0]              issue_imm,
   output logic [31:0]              issue_rs1_value,
   output logic [31:0]              issue_rs2_value,
   output logic [TAG_W-1:0]         issue_tag,
   output logic [ROB_W-1:0]         issue_rob_index,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   fu_op_t            mem [DEPTH];
   fu_op_t            in_op;
   fu_op_t            head_op;
   logic [AW-1:0]     head;
   logic [AW-1:0]     tail;
   logic [PW-1:0]     rr_ptr;
   logic [NUM_FU-1:0] grant;
   logic [PW-1:0]     grant_idx;
   logic              grant_any;
   logic              enq;
   logic              issue;

   assign in_op = '{alu_control: in_alu_control, alu_src: in_alu_src,
                    is_for_lsq: in_is_for_lsq, imm: in_imm,
                    rs1_value: in_rs1_value, rs2_value: in_rs2_value,
                    tag: in_tag, rob_index: in_rob_index};

   rr_picker #(.N(NUM_FU), .PW(PW)) u_picker (
      .req       (fu_is_available),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (grant_any)
   );

   // Full means not ready even if the head pops this cycle.
   assign in_ready        = (count < CW'(DEPTH));
   assign enq             = in_valid && in_ready && !flush;
   assign issue           = (count != '0) && grant_any && !flush;
   assign fu_write_enable = issue ? grant : '0;

   assign head_op           = mem[head];
   assign issue_alu_control = head_op.alu_control;
   assign issue_alu_src     = head_op.alu_src;
   assign issue_is_for_lsq  = head_op.is_for_lsq;
   assign issue_imm         = head_op.imm;
   assign issue_rs1_value   = head_op.rs1_value;
   assign issue_rs2_value   = head_op.rs2_value;
   assign issue_tag         = head_op.tag;
   assign issue_rob_index   = head_op.rob_index;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (enq) begin
         mem[tail] <= in_op;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         rr_ptr <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + AW'(1);
         if (issue) begin
            head   <= head + AW'(1);
            rr_ptr <= (grant_idx == PW'(NUM_FU - 1)) ? '0 : grant_idx + PW'(1);
         end
         unique case ({enq, issue})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fu_issue_queue.sv
// Directed bench for fu_issue_queue: expected issues are queued by the
// stimulus thread and consumed by an independent negedge monitor.
module tb_fu_issue_queue;
   import fu_pkg::*;

   localparam int DEPTH  = 8;
   localparam int NUM_FU = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        in_alu_control = '0;
   logic              in_alu_src = 1'b0;
   logic              in_is_for_lsq = 1'b0;
   logic [31:0]       in_imm = '0;
   logic [31:0]       in_rs1_value = '0;
   logic [31:0]       in_rs2_value = '0;
   logic [5:0]        in_tag = '0;
   logic [5:0]        in_rob_index = '0;
   logic [NUM_FU-1:0] fu_is_available = '0;
   logic [NUM_FU-1:0] fu_write_enable;
   logic [3:0]        issue_alu_control;
   logic              issue_alu_src;
   logic              issue_is_for_lsq;
   logic [31:0]       issue_imm;
   logic [31:0]       issue_rs1_value;
   logic [31:0]       issue_rs2_value;
   logic [5:0]        issue_tag;
   logic [5:0]        issue_rob_index;
   logic [3:0]        count;

   fu_issue_queue #(.DEPTH(DEPTH), .NUM_FU(NUM_FU)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .flush             (flush),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_alu_control    (in_alu_control),
      .in_alu_src        (in_alu_src),
      .in_is_for_lsq     (in_is_for_lsq),
      .in_imm            (in_imm),
      .in_rs1_value      (in_rs1_value),
      .in_rs2_value      (in_rs2_value),
      .in_tag            (in_tag),
      .in_rob_index      (in_rob_index),
      .fu_is_available   (fu_is_available),
      .fu_write_enable   (fu_write_enable),
      .issue_alu_control (issue_alu_control),
      .issue_alu_src     (issue_alu_src),
      .issue_is_for_lsq  (issue_is_for_lsq),
      .issue_imm         (issue_imm),
      .issue_rs1_value   (issue_rs1_value),
      .issue_rs2_value   (issue_rs2_value),
      .issue_tag         (issue_tag),
      .issue_rob_index   (issue_rob_index),
      .count             (count)
   );

   always #5 clk = ~clk;

   typedef struct { int fu; int rob; } exp_t;
   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [3:0] ctrl_of(input int r);
      logic [31:0] v;
      v = 32'(r);
      if (r < 10) return ALU_ADD;
      return v[0] ? ALU_XOR : ALU_SRA;
   endfunction
   function automatic logic [31:0] imm_of(input int r); return 32'h1000_0000 + 32'(r * 17); endfunction
   function automatic logic [31:0] rs1_of(input int r); return 32'hA5A5_0000 ^ 32'(r); endfunction
   function automatic logic [31:0] rs2_of(input int r); return ~32'(r); endfunction
   function automatic logic [5:0]  tag_of(input int r); return 6'(r + 3); endfunction
   function automatic logic        src_of(input int r); logic [31:0] v; v = 32'(r); return v[0]; endfunction
   function automatic logic        lsq_of(input int r); logic [31:0] v; v = 32'(r); return v[1]; endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int r);
      in_valid       = 1'b1;
      in_alu_control = ctrl_of(r);
      in_alu_src     = src_of(r);
      in_is_for_lsq  = lsq_of(r);
      in_imm         = imm_of(r);
      in_rs1_value   = rs1_of(r);
      in_rs2_value   = rs2_of(r);
      in_tag         = tag_of(r);
      in_rob_index   = 6'(r);
   endtask

   task automatic expect_issue(input int fu, input int rob);
      exp_t e;
      e.fu  = fu;
      e.rob = rob;
      exp_q.push_back(e);
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (count != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_within_budget", 64'(count == 0), 64'd1);
   endtask

   // Monitor: every issue must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && fu_write_enable != '0) begin
         chk("we_subset_of_avail", 64'(fu_write_enable & ~fu_is_available), 64'd0);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_issue: we=%b rob=%0d, expected no issue", fu_write_enable, issue_rob_index);
         end else begin
            e = exp_q.pop_front();
            chk("issue_fu",       64'(fu_write_enable), 64'(1 << e.fu));
            chk("issue_rob",      64'(issue_rob_index), 64'(e.rob));
            chk("issue_ctrl",     64'(issue_alu_control), 64'(ctrl_of(e.rob)));
            chk("issue_src",      64'(issue_alu_src), 64'(src_of(e.rob)));
            chk("issue_lsq",      64'(issue_is_for_lsq), 64'(lsq_of(e.rob)));
            chk("issue_imm",      64'(issue_imm), 64'(imm_of(e.rob)));
            chk("issue_rs1",      64'(issue_rs1_value), 64'(rs1_of(e.rob)));
            chk("issue_rs2",      64'(issue_rs2_value), 64'(rs2_of(e.rob)));
            chk("issue_tag",      64'(issue_tag), 64'(tag_of(e.rob)));
         end
      end
   end

   initial begin
      // reset and idle
      tick();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_we",    64'(fu_write_enable), 64'd0);
      chk("rst_tag",   64'(issue_tag), 64'd0);
      tick();
      reset_n = 1'b1;
      fu_is_available = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_count", 64'(count), 64'd0);
         chk("idle_ready", 64'(in_ready), 64'd1);
         chk("idle_we",    64'(fu_write_enable), 64'd0);
      end

      // back-to-back, all FUs free
      expect_issue(0, 1); expect_issue(1, 2); expect_issue(2, 3);
      expect_issue(3, 4); expect_issue(0, 5);
      for (int r = 1; r <= 5; r++) begin
         send(r);
         tick();
         chk("b2b_count_le1", 64'(count <= 1), 64'd1);
      end
      in_valid = 1'b0;
      wait_empty(10);

      // fill and backpressure; rr_ptr is now 1
      fu_is_available = 4'b0000;
      for (int r = 10; r <= 18; r++) begin
         send(r);
         tick();
      end
      in_valid = 1'b0;
      chk("full_count", 64'(count), 64'd8);
      chk("full_ready", 64'(in_ready), 64'd0);
      for (int r = 10; r <= 17; r++) expect_issue(2, r);
      fu_is_available = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("drain_fu2_count", 64'(count), 64'(7 - i));
      end

      // count 7 with enqueue+issue together; rr_ptr is now 3
      fu_is_available = 4'b0000;
      for (int r = 20; r <= 26; r++) begin
         send(r);
         tick();
      end
      chk("seven_count", 64'(count), 64'd7);
      chk("seven_ready", 64'(in_ready), 64'd1);
      expect_issue(3, 20); expect_issue(0, 21); expect_issue(1, 22);
      expect_issue(2, 23); expect_issue(3, 24); expect_issue(0, 25);
      expect_issue(1, 26); expect_issue(2, 27); expect_issue(3, 28);
      fu_is_available = 4'b1111;
      send(27);
      tick();
      chk("enq_issue_count_a", 64'(count), 64'd7);
      send(28);
      tick();
      chk("enq_issue_count_b", 64'(count), 64'd7);
      in_valid = 1'b0;
      wait_empty(20);

      // rotation skipping busy units; rr_ptr is now 0
      expect_issue(0, 30); expect_issue(3, 31); expect_issue(0, 32);
      send(30);
      tick();
      in_valid = 1'b0;
      tick();
      fu_is_available = 4'b0000;
      send(31);
      tick();
      send(32);
      tick();
      in_valid = 1'b0;
      fu_is_available = 4'b1001;
      tick();
      chk("rot_count_a", 64'(count), 64'd1);
      tick();
      chk("rot_count_b", 64'(count), 64'd0);

      // flush with count 5; rr_ptr is now 1 and must survive
      fu_is_available = 4'b0000;
      for (int r = 40; r <= 44; r++) begin
         send(r);
         tick();
      end
      chk("pre_flush_count", 64'(count), 64'd5);
      flush = 1'b1;
      fu_is_available = 4'b1111;
      send(45);
      #1;
      chk("flush_cycle_we", 64'(fu_write_enable), 64'd0);
      tick();
      chk("post_flush_count", 64'(count), 64'd0);
      flush = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_dropped_count", 64'(count), 64'd0);
      end
      expect_issue(1, 46);
      send(46);
      tick();
      in_valid = 1'b0;
      wait_empty(10);

      // async reset mid-issue; rr_ptr is now 2
      fu_is_available = 4'b0000;
      for (int r = 50; r <= 52; r++) begin
         send(r);
         tick();
      end
      in_valid = 1'b0;
      chk("pre_reset_count", 64'(count), 64'd3);
      fu_is_available = 4'b1111;
      #1;
      chk("pre_reset_we", 64'(fu_write_enable), 64'b0100);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_rst_we",    64'(fu_write_enable), 64'd0);
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_ready", 64'(in_ready), 64'd1);
      chk("async_rst_rob",   64'(issue_rob_index), 64'd0);
      chk("async_rst_imm",   64'(issue_imm), 64'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("post_rst_count", 64'(count), 64'd0);
      expect_issue(0, 60);
      send(60);
      tick();
      in_valid = 1'b0;
      wait_empty(10);

      tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
